flag_register_unit: RTL
=======================

// Module: flag_register_unit
// PURPOSE
//  - Holds the architectural condition-code register (CCR) {C,N,Z} fed by the execute-stage ALU.
//  - Evaluates conditional jumps (JZ/JN/JC/JMP) against the current flags.
//  - Keeps a LIFO shadow stack of flags for interrupt entry (save) and RTI (restore).
//  - Sits directly downstream of the ALU in the execute stage; branch_taken drives the fetch-stage PC mux.
// PARAMETERS
//  - DEPTH     default 2   shadow-stack entries (nested interrupt depth), >=1
//  - PTR_W     default 2   stack pointer width; holds 0..DEPTH, so PTR_W >= clog2(DEPTH+1)
// PORTS
//  - clk          in   1   single clock, rising edge
//  - rst_n        in   1   asynchronous, active-low reset
//  - stall        in   1   pipeline stall; freezes all state
//  - ccr_in       in   3   {C,N,Z} from ALU conditionCodeRegister
//  - ccr_write    in   1   latch ccr_in into the CCR this cycle
//  - br_valid     in   1   jump instruction present in execute
//  - br_type      in   2   00=JZ, 01=JN, 10=JC, 11=JMP (unconditional)
//  - int_save     in   1   interrupt entry: push current flags
//  - rti_restore  in   1   RTI: pop flags into the CCR
//  - flags        out  3   registered CCR {C,N,Z}
//  - branch_taken out  1   combinational jump decision
//  - stack_cnt    out  PTR_W  number of valid shadow entries
//  - ovf_err      out  1   sticky: push attempted while full
//  - unf_err      out  1   sticky: pop attempted while empty
// BEHAVIOUR
//  - Reset (async, rst_n=0): flags=000, stack_cnt=0, ovf_err=0, unf_err=0, all stack entries=000.
//  - Effective flags eff = ccr_write ? ccr_in : flags (same-cycle bypass of the ALU result).
//  - branch_taken = br_valid & ~stall & (JZ:eff.Z | JN:eff.N | JC:eff.C | JMP:1). Zero latency.
//  - Next-state priority when stall=0, highest first:
//    1. rti_restore: if stack_cnt>0, flags <= top entry and stack_cnt-1;
//       else flags unchanged and unf_err <= 1.
//    2. int_save: push eff; if stack_cnt==DEPTH, no push and ovf_err <= 1.
//       flags <= eff, including any clear from rule 3.
//    3. Otherwise flags <= eff, with jump clearing per CONFIGURATION.
//  - int_save and rti_restore together: restore wins and save is ignored; no error is flagged for the ignored save.
//  - stall=1: no register changes, branch_taken=0, and errors are not set.
//  - Update latency: flags changes are visible one clock after the triggering cycle.
//  - Stack is LIFO and does not wrap. Entry index = stack_cnt-1 is the top.
//  - Error flags are sticky until reset.
//  - Reset mid-operation clears the stack; a pending restore after reset reports underflow.
// CONFIGURATION
//  - Macro CCR_CLEAR_ON_TAKEN_EN:
//    - defined: a taken JZ/JN/JC clears the tested bit in the next flags value (Z, N or C respectively).
//      The clear is applied after the ccr_write bypass. JMP clears nothing.
//      When int_save is in the same cycle, the value pushed is eff before the clear.
//    - undefined: jumps never modify flags; flags <= eff only.
// TESTING
//  - Reset: drive rst_n=0 asynchronously mid-cycle -> flags=000, stack_cnt=0, ovf_err=0, unf_err=0 immediately.
//  - Bypass: ccr_write=1, ccr_in=001, br_valid=1, br_type=JZ in the same cycle -> branch_taken=1.
//    Next cycle: flags=000 if CCR_CLEAR_ON_TAKEN_EN is defined, else 001.
//  - Nesting: flags=100, int_save -> stack_cnt=1; ccr_write 010, int_save -> stack_cnt=2;
//    a third int_save -> ovf_err=1 and stack_cnt stays 2.
//  - Restore: with the stack above, rti_restore x2 -> flags 010 then 100, stack_cnt 1 then 0;
//    a third rti_restore -> unf_err=1 and flags stay 100.
//  - Stall: stall=1 with ccr_write=1, ccr_in=111, br_valid=1, br_type=JMP
//    -> branch_taken=0, flags unchanged, stack_cnt unchanged.
//  - Collision: int_save=1 and rti_restore=1 with stack_cnt=1 holding 010
//    -> flags=010, stack_cnt=0, ovf_err=0.

Source files
------------

// File: rtl/flag_register_unit_if.sv
// ---------------------------------------------------------------------------
// flag_register_unit_if
//   Groups the execute-stage signals of the flag register unit into a single
//   bundle. The interface carries everything except clk and rst_n.
//
//   Parameters
//     PTR_W         width of stack_cnt (must match the unit's PTR_W)
//
//   Signals
//     stall         pipeline stall, freezes all state
//     ccr_in[2:0]   {C,N,Z} from the ALU
//     ccr_write     latch ccr_in into the CCR this cycle
//     br_valid      jump instruction present in execute
//     br_type[1:0]  00=JZ, 01=JN, 10=JC, 11=JMP
//     int_save      interrupt entry: push current flags
//     rti_restore   RTI: pop flags into the CCR
//     flags[2:0]    registered CCR {C,N,Z}
//     branch_taken  combinational jump decision
//     stack_cnt     number of valid shadow entries
//     ovf_err       sticky push-while-full error
//     unf_err       sticky pop-while-empty error
//
//   Modports
//     master        pipeline side (drives the requests, observes the results)
//     slave         flag register unit side
// ---------------------------------------------------------------------------
interface flag_register_unit_if #(
   parameter int PTR_W = 2
);
   logic             stall;
   logic [2:0]       ccr_in;
   logic             ccr_write;
   logic             br_valid;
   logic [1:0]       br_type;
   logic             int_save;
   logic             rti_restore;
   logic [2:0]       flags;
   logic             branch_taken;
   logic [PTR_W-1:0] stack_cnt;
   logic             ovf_err;
   logic             unf_err;

   modport master (
      output stall,
      output ccr_in,
      output ccr_write,
      output br_valid,
      output br_type,
      output int_save,
      output rti_restore,
      input  flags,
      input  branch_taken,
      input  stack_cnt,
      input  ovf_err,
      input  unf_err
   );

   modport slave (
      input  stall,
      input  ccr_in,
      input  ccr_write,
      input  br_valid,
      input  br_type,
      input  int_save,
      input  rti_restore,
      output flags,
      output branch_taken,
      output stack_cnt,
      output ovf_err,
      output unf_err
   );
endinterface

// File: rtl/flag_register_unit.sv
// ---------------------------------------------------------------------------
// flag_register_unit
//   Architectural condition-code register {C,N,Z} for the execute stage.
//   - Latches ALU flags, with a same-cycle bypass used by jump evaluation.
//   - Evaluates JZ/JN/JC/JMP combinationally; branch_taken feeds the PC mux.
//   - Keeps a LIFO shadow stack of flags for interrupt entry / RTI.
//
//   Optional feature macro: CCR_CLEAR_ON_TAKEN_EN
//     defined   : a taken JZ/JN/JC clears the tested bit in the next flags
//                 value (after the ccr_write bypass); JMP clears nothing.
//                 A same-cycle int_save pushes the value before the clear.
//     undefined : jumps never modify the flags.
//
//   Parameters
//     DEPTH   shadow-stack entries (>= 1)
//     PTR_W   stack pointer width, must hold 0..DEPTH
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     flag_register_unit_if.slave (see interface file for signals)
// ---------------------------------------------------------------------------
module flag_register_unit #(
   parameter int DEPTH = 2,
   parameter int PTR_W = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   flag_register_unit_if.slave  bus
);

   typedef enum logic [1:0] {
      BR_JZ  = 2'b00,
      BR_JN  = 2'b01,
      BR_JC  = 2'b10,
      BR_JMP = 2'b11
   } br_type_t;

   // Bit positions inside the {C,N,Z} vector.
   localparam int C_BIT = 2;
   localparam int N_BIT = 1;
   localparam int Z_BIT = 0;

   localparam logic [PTR_W-1:0] CNT_ZERO = '0;
   localparam logic [PTR_W-1:0] CNT_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(DEPTH);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [2:0]       flags_reg;
   logic [2:0]       flags_next;
   logic [PTR_W-1:0] cnt_reg;
   logic [PTR_W-1:0] cnt_next;
   logic             ovf_reg;
   logic             ovf_next;
   logic             unf_reg;
   logic             unf_next;
   logic [2:0]       stack_reg [DEPTH];

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic [2:0]       eff;          // flags as seen this cycle (bypassed)
   logic             cond_met;
   logic             taken;
   logic [2:0]       eff_cleared;  // eff after optional jump clearing
   logic [2:0]       top_entry;
   logic             push_en;
   logic [DEPTH-1:0] entry_we;

   // A jump in the same cycle as the ALU write must see the new flags.
   assign eff = bus.ccr_write ? bus.ccr_in : flags_reg;

   always_comb begin
      cond_met = 1'b0;
      case (br_type_t'(bus.br_type))
         BR_JZ:   cond_met = eff[Z_BIT];
         BR_JN:   cond_met = eff[N_BIT];
         BR_JC:   cond_met = eff[C_BIT];
         BR_JMP:  cond_met = 1'b1;
         default: cond_met = 1'b0;
      endcase
   end

   // A stalled jump is not yet committed, so it must not redirect fetch.
   assign taken = bus.br_valid & ~bus.stall & cond_met;

`ifdef CCR_CLEAR_ON_TAKEN_EN
   always_comb begin
      eff_cleared = eff;
      if (taken) begin
         case (br_type_t'(bus.br_type))
            BR_JZ:   eff_cleared[Z_BIT] = 1'b0;
            BR_JN:   eff_cleared[N_BIT] = 1'b0;
            BR_JC:   eff_cleared[C_BIT] = 1'b0;
            default: eff_cleared = eff;
         endcase
      end
   end
`else
   assign eff_cleared = eff;
`endif

   // Select the top of stack (index cnt_reg-1) with a compare-per-entry mux
   // so no index arithmetic has to fit the array bounds.
   always_comb begin
      top_entry = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (cnt_reg == PTR_W'(i + 1)) begin
            top_entry = stack_reg[i];
         end
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. Priority: restore, then save, then plain update.
   // ------------------------------------------------------------------
   always_comb begin
      flags_next = flags_reg;
      cnt_next   = cnt_reg;
      ovf_next   = ovf_reg;
      unf_next   = unf_reg;
      push_en    = 1'b0;

      if (!bus.stall) begin
         if (bus.rti_restore) begin
            // A simultaneous int_save is dropped silently.
            if (cnt_reg != CNT_ZERO) begin
               flags_next = top_entry;
               cnt_next   = cnt_reg - CNT_ONE;
            end else begin
               unf_next   = 1'b1;
            end
         end else begin
            flags_next = eff_cleared;
            if (bus.int_save) begin
               if (cnt_reg == CNT_FULL) begin
                  ovf_next = 1'b1;
               end else begin
                  push_en  = 1'b1;
                  cnt_next = cnt_reg + CNT_ONE;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_reg <= '0;
         cnt_reg   <= '0;
         ovf_reg   <= 1'b0;
         unf_reg   <= 1'b0;
      end else begin
         flags_reg <= flags_next;
         cnt_reg   <= cnt_next;
         ovf_reg   <= ovf_next;
         unf_reg   <= unf_next;
      end
   end

   // Shadow stack: each entry is written only when it is the next free slot.
   // The pushed value is the un-cleared eff so RTI returns the flags the
   // interrupted code actually saw.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stack
         assign entry_we[gi] = push_en && (cnt_reg == PTR_W'(gi));

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               stack_reg[gi] <= '0;
            end else if (entry_we[gi]) begin
               stack_reg[gi] <= eff;
            end
         end
      end
   endgenerate

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.flags        = flags_reg;
   assign bus.branch_taken = taken;
   assign bus.stack_cnt    = cnt_reg;
   assign bus.ovf_err      = ovf_reg;
   assign bus.unf_err      = unf_reg;

endmodule
